// File: rtl/mips_pkg.sv
// Shared core definitions: text segment base, fetch run-control state
// encoding, the nop instruction word and the 16-bit sign-extension helper.
package mips_pkg;

  localparam logic [31:0] TEXT_BASE_DEFAULT = 32'h0000_3000;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_RUN   = 2'd0,
    FETCH_HALT  = 2'd1,
    FETCH_FAULT = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] sign_extend16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC selection: jump_reg > jump > branch > sequential,
// followed by an alignment and text-segment range check of the chosen target.
module npc_calc
  import mips_pkg::*;
#(
  parameter int          BUS_WIDTH = 10,
  parameter logic [31:0] TEXT_BASE = TEXT_BASE_DEFAULT
) (
  input  logic [31:0] pc_plus4,
  input  logic        branch_taken,
  input  logic [15:0] branch_off,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jump_reg,
  input  logic [31:0] reg_target,
  output logic [31:0] target,
  output logic        bad
);

  // One past the last ROM byte, held in 33 bits so a segment ending at the
  // top of the address space cannot wrap to zero.
  localparam logic [32:0] TEXT_LIMIT = {1'b0, TEXT_BASE} + (33'd4 << BUS_WIDTH);

  logic [31:0] branch_target;
  logic [31:0] jump_target;

  assign branch_target = pc_plus4 + (sign_extend16(branch_off) << 2);
  assign jump_target   = {pc_plus4[31:28], jump_index, 2'b00};

  // Priority mux of the redirect requests.
  always_comb begin
    target = pc_plus4;
    if (jump_reg) begin
      target = reg_target;
    end else if (jump) begin
      target = jump_target;
    end else if (branch_taken) begin
      target = branch_target;
    end
  end

  // Target must be word aligned and inside [TEXT_BASE, TEXT_LIMIT).
  always_comb begin
    bad = 1'b0;
    if (target[1:0] != 2'b00) begin
      bad = 1'b1;
    end else if (target < TEXT_BASE) begin
      bad = 1'b1;
    end else if ({1'b0, target} >= TEXT_LIMIT) begin
      bad = 1'b1;
    end
  end

endmodule

// File: rtl/fetch_pc.sv
// Program counter, zero-latency instruction fetch, RUN/HALT/FAULT run control
// and retired-instruction counter of the single-cycle core.
// Flow control: stall is a plain hold request with no handshake; when stall=1
// in RUN the stage keeps pc, state and retired unchanged and the redirect /
// halt inputs of that cycle are discarded, so execute must re-present them.
module fetch_pc
  import mips_pkg::*;
#(
  parameter int          BUS_WIDTH = 10,
  parameter logic [31:0] TEXT_BASE = TEXT_BASE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 branch_taken,
  input  logic [15:0]          branch_off,
  input  logic                 jump,
  input  logic [25:0]          jump_index,
  input  logic                 jump_reg,
  input  logic [31:0]          reg_target,
  input  logic                 halt_req,
  input  logic                 resume,
  output logic [BUS_WIDTH-1:0] ins_addr,
  input  logic [31:0]          ins_rdata,
  output logic [31:0]          instr,
  output logic [31:0]          pc,
  output logic [31:0]          pc_plus4,
  output logic                 halted,
  output logic                 fault,
  output logic [31:0]          fault_pc,
  output logic [31:0]          retired
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  fault_pc_q, fault_pc_d;
  logic [31:0]  retired_q, retired_d;

  logic         run_mode;
  logic [31:0]  npc_target;
  logic         npc_bad;

  assign run_mode = (state_q == FETCH_RUN);

  assign pc       = pc_q;
  assign pc_plus4 = pc_q + 32'd4;
  assign ins_addr = BUS_WIDTH'((pc_q - TEXT_BASE) >> 2);
  assign instr    = run_mode ? ins_rdata : INSTR_NOP;
  assign halted   = (state_q == FETCH_HALT);
  assign fault    = (state_q == FETCH_FAULT);
  assign fault_pc = fault_pc_q;
  assign retired  = retired_q;

  // Redirects only matter in RUN; outside RUN the calculator is fed zeros so
  // it yields the checked sequential target used by resume.
  npc_calc #(
    .BUS_WIDTH (BUS_WIDTH),
    .TEXT_BASE (TEXT_BASE)
  ) u_npc_calc (
    .pc_plus4     (pc_plus4),
    .branch_taken (branch_taken & run_mode),
    .branch_off   (branch_off),
    .jump         (jump & run_mode),
    .jump_index   (jump_index),
    .jump_reg     (jump_reg & run_mode),
    .reg_target   (reg_target),
    .target       (npc_target),
    .bad          (npc_bad)
  );

  // Next-state logic for run control, pc, fault address and retire count.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fault_pc_d = fault_pc_q;
    retired_d  = retired_q;
    case (state_q)
      FETCH_RUN: begin
        if (!stall) begin
          if (halt_req) begin
            // The exit syscall itself retires; pc stays on it.
            state_d   = FETCH_HALT;
            retired_d = retired_q + 32'd1;
          end else if (npc_bad) begin
            state_d    = FETCH_FAULT;
            fault_pc_d = npc_target;
          end else begin
            pc_d      = npc_target;
            retired_d = retired_q + 32'd1;
          end
        end
      end
      FETCH_HALT: begin
        if (resume) begin
          if (npc_bad) begin
            state_d    = FETCH_FAULT;
            fault_pc_d = npc_target;
          end else begin
            state_d = FETCH_RUN;
            pc_d    = npc_target;
          end
        end
      end
      FETCH_FAULT: begin
        state_d = FETCH_FAULT;
      end
      default: begin
        state_d = FETCH_FAULT;
      end
    endcase
  end

  // State register with synchronous reset to the text base in RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH_RUN;
      pc_q       <= TEXT_BASE;
      fault_pc_q <= 32'h0000_0000;
      retired_q  <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fault_pc_q <= fault_pc_d;
      retired_q  <= retired_d;
    end
  end

endmodule
